// File: rtl/mcac_timer.sv
// MCAC programmable interval timer: 8-bit prescaler feeding a 16-bit period counter.
// Optional one-shot behaviour is built only when TIMER_ONESHOT_EN is defined.
module mcac_timer #(
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic [PRE_W-1:0] i_prescale,
  input  logic [CNT_W-1:0] i_period,
  input  logic             i_load_en,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_mode,
  input  logic             i_irq_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tick,
  output logic             o_expire,
  output logic             o_irq,
  input  logic             i_scan_in0,
  input  logic             i_scan_in1,
  input  logic             i_scan_in2,
  input  logic             i_scan_in3,
  input  logic             i_scan_in4,
  input  logic             i_scan_enable,
  input  logic             i_test_mode,
  output logic             o_scan_out0,
  output logic             o_scan_out1,
  output logic             o_scan_out2,
  output logic             o_scan_out3,
  output logic             o_scan_out4
);

  logic [PRE_W-1:0] r_preCnt;
  logic [CNT_W-1:0] r_count;
  logic             r_tick;
  logic             r_expire;
  logic             r_irq;
  logic             w_run;
  logic             w_tickEv;
  logic             w_expireSet;
  logic             w_unused;

`ifdef TIMER_ONESHOT_EN
  logic r_done;

  // A completed one-shot freezes the timer until reloaded or switched to periodic.
  assign w_run = i_enable && !(r_done && i_mode);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done <= 1'b0;
    end else if (i_load_en || !i_mode) begin
      r_done <= 1'b0;
    end else if (w_expireSet) begin
      r_done <= 1'b1;
    end
  end

  assign w_unused = ^{i_scan_in0, i_scan_in1, i_scan_in2, i_scan_in3,
                      i_scan_in4, i_scan_enable, i_test_mode};
`else
  assign w_run    = i_enable;
  assign w_unused = ^{i_scan_in0, i_scan_in1, i_scan_in2, i_scan_in3,
                      i_scan_in4, i_scan_enable, i_test_mode, i_mode};
`endif

  assign w_tickEv    = !i_load_en && w_run && (r_preCnt == i_prescale);
  assign w_expireSet = w_tickEv && (r_count == i_period);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_preCnt <= '0;
      r_count  <= '0;
      r_tick   <= 1'b0;
      r_expire <= 1'b0;
    end else if (i_load_en) begin
      r_preCnt <= '0;
      r_count  <= i_load_val;
      r_tick   <= 1'b0;
      r_expire <= 1'b0;
    end else if (w_tickEv) begin
      r_preCnt <= '0;
      r_tick   <= 1'b1;
      r_expire <= w_expireSet;
      r_count  <= w_expireSet ? '0 : r_count + CNT_W'(1);
    end else begin
      if (w_run) begin
        r_preCnt <= r_preCnt + PRE_W'(1);
      end
      r_tick   <= 1'b0;
      r_expire <= 1'b0;
    end
  end

  // Setting wins over a coincident clear so no expire is ever lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq <= 1'b0;
    end else if (w_expireSet) begin
      r_irq <= 1'b1;
    end else if (i_irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign o_count  = r_count;
  assign o_tick   = r_tick;
  assign o_expire = r_expire;
  assign o_irq    = r_irq;

  assign o_scan_out0 = 1'b0;
  assign o_scan_out1 = 1'b0;
  assign o_scan_out2 = 1'b0;
  assign o_scan_out3 = 1'b0;
  assign o_scan_out4 = 1'b0;

endmodule

// File: tb/tb_mcac_timer.sv
// Directed self-checking bench for mcac_timer; expected values are hand-derived
// edge counts. One-shot checks assume TIMER_ONESHOT_EN matches the RTL build.
module tb_mcac_timer;

  logic        clk;
  logic        rstN;
  logic        enable;
  logic [7:0]  prescale;
  logic [15:0] period;
  logic        loadEn;
  logic [15:0] loadVal;
  logic        mode;
  logic        irqClr;
  logic [15:0] count;
  logic        tick;
  logic        expire;
  logic        irq;
  logic        scanOut0, scanOut1, scanOut2, scanOut3, scanOut4;

  int nCompared;
  int nMismatched;

  mcac_timer dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_enable     (enable),
    .i_prescale   (prescale),
    .i_period     (period),
    .i_load_en    (loadEn),
    .i_load_val   (loadVal),
    .i_mode       (mode),
    .i_irq_clr    (irqClr),
    .o_count      (count),
    .o_tick       (tick),
    .o_expire     (expire),
    .o_irq        (irq),
    .i_scan_in0   (1'b1),
    .i_scan_in1   (1'b1),
    .i_scan_in2   (1'b1),
    .i_scan_in3   (1'b1),
    .i_scan_in4   (1'b1),
    .i_scan_enable(1'b1),
    .i_test_mode  (1'b1),
    .o_scan_out0  (scanOut0),
    .o_scan_out1  (scanOut1),
    .o_scan_out2  (scanOut2),
    .o_scan_out3  (scanOut3),
    .o_scan_out4  (scanOut4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rstN     = 1'b0;
    enable   = 1'b0;
    prescale = 8'd3;
    period   = 16'd2;
    loadEn   = 1'b0;
    loadVal  = 16'd0;
    mode     = 1'b0;
    irqClr   = 1'b0;
    #12;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rstN   = 1'b1;
    enable = 1'b1;

    // prescale=3, period=2: tick every 4th edge, expire every 12th.
    for (int e = 1; e <= 24; e++) begin
      applyStimulus(1);
      checkOutput($sformatf("p3_tick_e%0d", e), 32'(tick), 32'((e % 4) == 0));
      checkOutput($sformatf("p3_count_e%0d", e), 32'(count), 32'((e / 4) % 3));
      checkOutput($sformatf("p3_expire_e%0d", e), 32'(expire), 32'((e % 12) == 0));
      checkOutput($sformatf("p3_irq_e%0d", e), 32'(irq), 32'(e >= 12));
    end

    irqClr = 1'b1;
    applyStimulus(1);
    checkOutput("clr_alone_e25", 32'(irq), 32'd0);
    irqClr = 1'b0;
    applyStimulus(10);
    checkOutput("irq_low_e35", 32'(irq), 32'd0);
    irqClr = 1'b1;
    applyStimulus(1);
    checkOutput("clr_coinc_expire_e36", 32'(expire), 32'd1);
    checkOutput("clr_coinc_irq_e36", 32'(irq), 32'd1);
    applyStimulus(1);
    checkOutput("clr_later_e37", 32'(irq), 32'd0);
    irqClr = 1'b0;

    // Edge 48 would expire; a load on that edge must win.
    applyStimulus(10);
    checkOutput("pre_load_count_e47", 32'(count), 32'd2);
    loadEn  = 1'b1;
    loadVal = 16'h0005;
    applyStimulus(1);
    checkOutput("load_count", 32'(count), 32'd5);
    checkOutput("load_expire", 32'(expire), 32'd0);
    checkOutput("load_tick", 32'(tick), 32'd0);
    checkOutput("load_irq", 32'(irq), 32'd0);

    // prescale=0, period=0: tick and expire every enabled edge.
    prescale = 8'd0;
    period   = 16'd0;
    loadVal  = 16'd0;
    applyStimulus(1);
    loadEn = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      applyStimulus(1);
      checkOutput($sformatf("p0_tick_%0d", e), 32'(tick), 32'd1);
      checkOutput($sformatf("p0_expire_%0d", e), 32'(expire), 32'd1);
      checkOutput($sformatf("p0_count_%0d", e), 32'(count), 32'd0);
    end
    checkOutput("p0_irq", 32'(irq), 32'd1);

    enable = 1'b0;
    applyStimulus(2);
    checkOutput("dis_tick", 32'(tick), 32'd0);
    checkOutput("dis_expire", 32'(expire), 32'd0);
    checkOutput("dis_irq_hold", 32'(irq), 32'd1);

    // Reset mid-count: outputs drop before any clock edge.
    prescale = 8'd0;
    period   = 16'd9;
    enable   = 1'b1;
    applyStimulus(3);
    checkOutput("pre_rst_count", 32'(count), 32'd3);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("async_rst_count", 32'(count), 32'd0);
    checkOutput("async_rst_tick", 32'(tick), 32'd0);
    checkOutput("async_rst_expire", 32'(expire), 32'd0);
    checkOutput("async_rst_irq", 32'(irq), 32'd0);
    checkOutput("scan_outs", 32'({scanOut0, scanOut1, scanOut2, scanOut3, scanOut4}), 32'd0);

    // mode=1, prescale=0, period=4: expire on edge 5.
    @(negedge clk);
    period = 16'd4;
    mode   = 1'b1;
    rstN   = 1'b1;
    applyStimulus(4);
    checkOutput("os_count_e4", 32'(count), 32'd4);
    applyStimulus(1);
    checkOutput("os_expire_e5", 32'(expire), 32'd1);
    checkOutput("os_count_e5", 32'(count), 32'd0);
    applyStimulus(2);
    checkOutput("os_expire_e7", 32'(expire), 32'd0);
`ifdef TIMER_ONESHOT_EN
    checkOutput("os_frozen_count", 32'(count), 32'd0);
    checkOutput("os_frozen_tick", 32'(tick), 32'd0);
    loadEn  = 1'b1;
    loadVal = 16'd0;
    applyStimulus(1);
    loadEn = 1'b0;
    applyStimulus(1);
    checkOutput("os_resume_count", 32'(count), 32'd1);
    checkOutput("os_resume_tick", 32'(tick), 32'd1);
`else
    checkOutput("periodic_count_e7", 32'(count), 32'd2);
    checkOutput("periodic_tick_e7", 32'(tick), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mcac_timer.md
Name: mcac_timer

Overview:
- Programmable interval timer for the single-resource MCAC datapath.
- An 8-bit prescaler divides clk into ticks; a 16-bit up-counter counts ticks to a programmed period, then emits an expire pulse and a sticky interrupt.
- Provides the five-chain scan port set used by every MCAC block. Chains are stitched at DFT insertion, not in RTL.

Parameters:
- CNT_W, 16, width of main counter, period and load value
- PRE_W, 8, width of prescaler and prescale value

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run enable; low freezes prescaler and counter
- prescale  in  PRE_W  tick every prescale+1 enabled cycles
- period  in  CNT_W  counter terminal value; expire period = period+1 ticks
- load_en  in  1  synchronous load strobe
- load_val  in  CNT_W  value loaded into counter
- mode  in  1  0 = periodic, 1 = one-shot (see Optional Feature)
- irq_clr  in  1  clears irq
- count  out  CNT_W  current counter value
- tick  out  1  one-cycle prescaler pulse
- expire  out  1  one-cycle terminal-count pulse
- irq  out  1  sticky interrupt
- scan_in0..scan_in4  in  1 each  scan chain inputs
- scan_enable  in  1  scan shift enable
- test_mode  in  1  DFT test mode
- scan_out0..scan_out4  out  1 each  scan chain outputs

Behaviour:
- Reset asserted (reset=0, asynchronous): pre_cnt=0, count=0, tick=0, expire=0, irq=0, one-shot done flag=0.
- Prescaler
  - When enable=1: if pre_cnt==prescale then pre_cnt<=0 and tick<=1, else pre_cnt<=pre_cnt+1 and tick<=0.
  - prescale=0 gives tick high every enabled cycle.
  - tick is registered: high for exactly the one cycle after the terminal edge.
- Counter, on an internal tick event (same edge that sets tick):
  - If count==period: count<=0 and expire<=1.
  - Otherwise count<=count+1 and expire<=0.
  - Comparison is equality only. If load_val>period, count increments to all-ones, wraps to 0 with no expire, then continues.
  - period=0 gives an expire on every tick.
- enable=0: pre_cnt and count hold; tick and expire go 0 next cycle; irq holds.
- load_en=1 (any enable value):
  - count<=load_val, pre_cnt<=0, tick<=0, expire<=0, done flag cleared.
  - Load has priority over a coincident tick or expire.
- irq
  - Set on any edge where expire is set.
  - Cleared by irq_clr=1.
  - Set has priority over a coincident clear.
- Changing prescale or period mid-run takes effect at the next comparison; no other side effects.
- Scan ports
  - RTL drives scan_out0..4 = 0.
  - scan_in*, scan_enable and test_mode have no functional effect in RTL.
  - The DFT flow stitches five chains, in to out.

Optional Feature:
- Macro: TIMER_ONESHOT_EN.
- Defined:
  - mode=1 makes the timer one-shot. After the first expire the done flag sets.
  - While done is set, prescaler and counter freeze; count holds 0.
  - load_en or mode=0 clears done and resumes counting.
- Undefined: mode is ignored, the timer is always periodic, and no done flag is built.

Test Plan:
- Reset: drive reset=0 mid-count -> count, tick, expire, irq all 0 immediately, without waiting for a clock edge; scan_out0..4=0.
- Prescale=3, period=2, enable=1 -> tick every 4th cycle; count sequence 0,1,2,0; expire once per 12 cycles; irq set after first expire.
- Prescale=0, period=0 -> tick and expire high every enabled cycle; count stays 0.
- Load collision: load_en=1, load_val=0x0005 on the same edge count reaches period -> count=5, no expire, irq unchanged.
- irq_clr asserted on the same edge as a new expire -> irq stays 1; asserted alone on a later edge -> irq=0.
- With TIMER_ONESHOT_EN, mode=1, prescale=0, period=4 -> single expire after 5 cycles, count frozen at 0; load_en resumes counting.
